doodle_motion: RTL and testbench

- Physics/position stage directly upstream of the doodle game state machine.
- Produces the doodle position (object_x, object_y) and the current jump distance (up_count) that the state machine consumes.
- Reads back the one-hot state (q_I, q_Up, q_Down, q_Done) to choose rise, fall or hold.
- Advances once per video frame on Frame_tick, with per-frame velocity steps, gravity-style velocity decay and growth, and horizontal wrap-around.

---
 rtl/doodle_motion.sv | 156 +++++++++++++++
 tb/tb_doodle_motion.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/doodle_motion.sv
// Per-frame position/velocity stage for the doodle: rises, falls or holds according to the
// one-hot state fed back from the doodle state machine, with horizontal wrap-around.
module doodle_motion #(
    parameter int unsigned X_START  = 459,
    parameter int unsigned Y_START  = 495,
    parameter int unsigned H_MIN    = 144,
    parameter int unsigned H_MAX    = 774,
    parameter int unsigned V_TOP    = 45,
    parameter int unsigned V_BOT    = 515,
    parameter int unsigned STEP_X   = 4,
    parameter int unsigned V_INIT   = 8,
    parameter int unsigned V_MAX    = 8,
    parameter int unsigned G_PERIOD = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Frame_tick,
    input  logic       q_I,
    input  logic       q_Up,
    input  logic       q_Down,
    input  logic       q_Done,
    input  logic       BtnL,
    input  logic       BtnR,
    output logic [9:0] object_x,
    output logic [9:0] object_y,
    output logic [9:0] up_count,
    output logic       step_valid
);

    localparam int unsigned GW = (G_PERIOD > 1) ? $clog2(G_PERIOD) : 1;

    typedef enum logic [1:0] {ModeHold, ModeRise, ModeFall} mode_t;

    mode_t         mode;
    logic [9:0]    vel;
    logic [GW-1:0] gcnt;
    logic          q_up_d;
    logic          q_down_d;

    logic [3:0]    q_vec;
    logic          q_valid;
    logic          up_entry;
    logic          down_entry;

    logic [10:0]   y_ext;
    logic [10:0]   vel_ext;
    logic [10:0]   up_sum;
    logic [10:0]   nx;
    logic [9:0]    step_x;
    logic [9:0]    step_y;
    logic [9:0]    step_up;
    logic [9:0]    step_vel;
    logic [GW-1:0] step_gcnt;

    assign q_vec      = {q_I, q_Up, q_Down, q_Done};
    assign q_valid    = (q_vec != 4'd0) && ((q_vec & (q_vec - 4'd1)) == 4'd0);
    assign up_entry   = q_Up & ~q_up_d;
    assign down_entry = q_Down & ~q_down_d;

    // Candidate outputs of one frame step in the current mode.
    always_comb begin
        y_ext     = {1'b0, object_y};
        vel_ext   = {1'b0, vel};
        up_sum    = {1'b0, up_count} + vel_ext;
        step_y    = object_y;
        step_up   = up_count;
        step_vel  = vel;
        step_gcnt = gcnt + GW'(1);
        nx        = {1'b0, object_x};

        if (mode == ModeRise) begin
            if (y_ext < 11'(V_TOP) + vel_ext) begin
                step_y = 10'(V_TOP);
            end else begin
                step_y = 10'(y_ext - vel_ext);
            end
            // Keeps accumulating while y is pinned at the top so the jump still ends.
            step_up = up_sum[10] ? 10'h3FF : up_sum[9:0];
        end else if (mode == ModeFall) begin
            if (y_ext + vel_ext > 11'(V_BOT)) begin
                step_y = 10'(V_BOT);
            end else begin
                step_y = 10'(y_ext + vel_ext);
            end
        end

        if (gcnt == GW'(G_PERIOD - 1)) begin
            step_gcnt = '0;
            if (mode == ModeRise) begin
                step_vel = (vel > 10'd1) ? vel - 10'd1 : 10'd1;
            end else if (mode == ModeFall) begin
                step_vel = (vel < 10'(V_MAX)) ? vel + 10'd1 : 10'(V_MAX);
            end
        end

        if (BtnL && !BtnR) begin
            nx = {1'b0, object_x} - 11'(STEP_X);
            if (nx < 11'(H_MIN)) begin
                nx = nx + 11'(H_MAX - H_MIN);
            end
        end else if (BtnR && !BtnL) begin
            nx = {1'b0, object_x} + 11'(STEP_X);
            if (nx >= 11'(H_MAX)) begin
                nx = nx - 11'(H_MAX - H_MIN);
            end
        end
        step_x = nx[9:0];
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            mode       <= ModeHold;
            object_x   <= 10'(X_START);
            object_y   <= 10'(Y_START);
            up_count   <= '0;
            vel        <= '0;
            gcnt       <= '0;
            step_valid <= 1'b0;
            q_up_d     <= 1'b0;
            q_down_d   <= 1'b0;
        end else begin
            q_up_d     <= q_Up;
            q_down_d   <= q_Down;
            step_valid <= 1'b0;
            if (!q_valid) begin
                mode <= ModeHold;
            end else if (q_I) begin
                mode     <= ModeHold;
                object_x <= 10'(X_START);
                object_y <= 10'(Y_START);
                up_count <= '0;
                vel      <= '0;
                gcnt     <= '0;
            end else if (up_entry) begin
                mode     <= ModeRise;
                vel      <= 10'(V_INIT);
                gcnt     <= '0;
                up_count <= '0;
            end else if (down_entry) begin
                mode <= ModeFall;
                vel  <= 10'd1;
                gcnt <= '0;
            end else if (q_Done) begin
                mode <= ModeHold;
            end else if (Frame_tick && mode != ModeHold) begin
                object_x   <= step_x;
                object_y   <= step_y;
                up_count   <= step_up;
                vel        <= step_vel;
                gcnt       <= step_gcnt;
                step_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_doodle_motion.sv
// Directed self-checking bench for doodle_motion.
module tb_doodle_motion;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Frame_tick = 1'b0;
    logic       q_I = 1'b1;
    logic       q_Up = 1'b0;
    logic       q_Down = 1'b0;
    logic       q_Done = 1'b0;
    logic       BtnL = 1'b0;
    logic       BtnR = 1'b0;
    logic [9:0] object_x;
    logic [9:0] object_y;
    logic [9:0] up_count;
    logic       step_valid;

    int checks = 0;
    int failures = 0;

    doodle_motion dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Frame_tick(Frame_tick),
        .q_I       (q_I),
        .q_Up      (q_Up),
        .q_Down    (q_Down),
        .q_Done    (q_Done),
        .BtnL      (BtnL),
        .BtnR      (BtnR),
        .object_x  (object_x),
        .object_y  (object_y),
        .up_count  (up_count),
        .step_valid(step_valid)
    );

    always #5 Clk = ~Clk;

    task automatic set_q(input logic i, input logic u, input logic d, input logic dn);
        @(negedge Clk);
        q_I = i; q_Up = u; q_Down = d; q_Done = dn;
    endtask

    // One-cycle Frame_tick; returns at the negedge after the stepping posedge.
    task automatic frame(input logic l, input logic r);
        @(negedge Clk);
        BtnL = l; BtnR = r; Frame_tick = 1'b1;
        @(negedge Clk);
        Frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (object_x !== 10'd459 || object_y !== 10'd495 || up_count !== 10'd0 || step_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_state x=%0d y=%0d up=%0d sv=%b need 459/495/0/0",
                     object_x, object_y, up_count, step_valid);
        end
        @(negedge Clk) Reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            frame(1'b0, 1'b0);
            checks++;
            if (object_x !== 10'd459 || object_y !== 10'd495 || up_count !== 10'd0 || step_valid !== 1'b0) begin
                failures++;
                $display("FAIL idle_tick%0d x=%0d y=%0d up=%0d sv=%b need 459/495/0/0",
                         k, object_x, object_y, up_count, step_valid);
            end
        end
    endtask

    task automatic test_rise();
        set_q(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            frame(1'b0, 1'b0);
            if (k == 1) begin
                checks++;
                if (step_valid !== 1'b1 || object_y !== 10'd487 || up_count !== 10'd8) begin
                    failures++;
                    $display("FAIL rise_tick1 sv=%b y=%0d up=%0d need 1/487/8", step_valid, object_y, up_count);
                end
            end
            if (k == 4) begin
                checks++;
                if (object_y !== 10'd463 || up_count !== 10'd32) begin
                    failures++;
                    $display("FAIL rise_tick4 y=%0d up=%0d need 463/32", object_y, up_count);
                end
            end
        end
        checks++;
        if (object_y !== 10'd435 || up_count !== 10'd60 || object_x !== 10'd459) begin
            failures++;
            $display("FAIL rise_tick8 y=%0d up=%0d x=%0d need 435/60/459", object_y, up_count, object_x);
        end
        // Outputs hold between ticks.
        repeat (3) @(negedge Clk);
        checks++;
        if (object_y !== 10'd435 || step_valid !== 1'b0) begin
            failures++;
            $display("FAIL rise_hold y=%0d sv=%b need 435/0", object_y, step_valid);
        end
    endtask

    task automatic test_fall();
        set_q(1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 40; k++) begin
            frame(1'b0, 1'b0);
            if (k == 4) begin
                checks++;
                if (object_y !== 10'd439) begin
                    failures++;
                    $display("FAIL fall_tick4 y=%0d need 439", object_y);
                end
            end
            if (k == 5) begin
                checks++;
                if (object_y !== 10'd441 || up_count !== 10'd60) begin
                    failures++;
                    $display("FAIL fall_tick5 y=%0d up=%0d need 441/60", object_y, up_count);
                end
            end
        end
        checks++;
        if (object_y !== 10'd515 || up_count !== 10'd60) begin
            failures++;
            $display("FAIL fall_clamp y=%0d up=%0d need 515/60", object_y, up_count);
        end
    endtask

    task automatic test_rise_clamp();
        set_q(1'b1, 1'b0, 1'b0, 1'b0);
        set_q(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (338) frame(1'b0, 1'b0);
        checks++;
        if (object_y !== 10'd45 || up_count !== 10'd450) begin
            failures++;
            $display("FAIL rise_top y=%0d up=%0d need 45/450", object_y, up_count);
        end
        repeat (5) frame(1'b0, 1'b0);
        checks++;
        if (object_y !== 10'd45 || up_count !== 10'd455) begin
            failures++;
            $display("FAIL rise_clamped y=%0d up=%0d need 45/455", object_y, up_count);
        end
    endtask

    task automatic test_wrap();
        set_q(1'b1, 1'b0, 1'b0, 1'b0);
        set_q(1'b0, 1'b1, 1'b0, 1'b0);
        set_q(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (78) frame(1'b1, 1'b0);
        checks++;
        if (object_x !== 10'd147) begin
            failures++;
            $display("FAIL left_edge x=%0d need 147", object_x);
        end
        frame(1'b1, 1'b0);
        checks++;
        if (object_x !== 10'd773) begin
            failures++;
            $display("FAIL wrap_left x=%0d need 773", object_x);
        end
        frame(1'b0, 1'b1);
        checks++;
        if (object_x !== 10'd147) begin
            failures++;
            $display("FAIL wrap_right x=%0d need 147", object_x);
        end
        frame(1'b1, 1'b1);
        frame(1'b0, 1'b0);
        checks++;
        if (object_x !== 10'd147 || step_valid !== 1'b1) begin
            failures++;
            $display("FAIL both_btn x=%0d sv=%b need 147/1", object_x, step_valid);
        end
        BtnL = 1'b0; BtnR = 1'b0;
    endtask

    task automatic test_back_to_back();
        set_q(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        q_I = 1'b0; q_Up = 1'b1; Frame_tick = 1'b1;
        @(negedge Clk);
        Frame_tick = 1'b0;
        checks++;
        if (object_x !== 10'd459 || object_y !== 10'd495 || up_count !== 10'd0 || step_valid !== 1'b0) begin
            failures++;
            $display("FAIL entry_tick x=%0d y=%0d up=%0d sv=%b need 459/495/0/0",
                     object_x, object_y, up_count, step_valid);
        end
        frame(1'b0, 1'b0);
        checks++;
        if (object_y !== 10'd487 || up_count !== 10'd8) begin
            failures++;
            $display("FAIL entry_next y=%0d up=%0d need 487/8", object_y, up_count);
        end
    endtask

    task automatic test_freeze();
        // Invalid one-hot (Up and Down together) freezes.
        set_q(1'b0, 1'b1, 1'b1, 1'b0);
        frame(1'b0, 1'b0);
        checks++;
        if (object_y !== 10'd487 || up_count !== 10'd8 || step_valid !== 1'b0) begin
            failures++;
            $display("FAIL invalid_freeze y=%0d up=%0d sv=%b need 487/8/0", object_y, up_count, step_valid);
        end
        set_q(1'b0, 1'b0, 1'b0, 1'b1);
        frame(1'b1, 1'b0);
        checks++;
        if (object_y !== 10'd487 || object_x !== 10'd459 || step_valid !== 1'b0) begin
            failures++;
            $display("FAIL done_freeze y=%0d x=%0d sv=%b need 487/459/0", object_y, object_x, step_valid);
        end
        BtnL = 1'b0;
    endtask

    task automatic test_reset_mid();
        set_q(1'b1, 1'b0, 1'b0, 1'b0);
        set_q(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) frame(1'b0, 1'b1);
        #2 Reset = 1'b0;
        #1;
        checks++;
        if (object_x !== 10'd459 || object_y !== 10'd495 || up_count !== 10'd0 || step_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid x=%0d y=%0d up=%0d sv=%b need 459/495/0/0",
                     object_x, object_y, up_count, step_valid);
        end
        BtnR = 1'b0;
        @(negedge Clk) Reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rise();
        test_fall();
        test_rise_clamp();
        test_wrap();
        test_back_to_back();
        test_freeze();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
